model_table_decoder: RTL and testbench
======================================

# model_table_decoder

Decoder-side counterpart of the encoder's adaptive model. It loads the bypass table that the encoder streams out, one 24-bit `{symbol, range}` entry per new symbol in first-seen order, and rebuilds the cumulative bounds in the same order. It then answers arithmetic-decoder lookups: a scaled target count goes in; the owning symbol and its lower bound, upper bound and range come out. It sits between the bitstream header parser and the arithmetic decoder core.

## Interface
- `MAX_ENTRIES`, 256, table depth; 9-bit entry count.
- `CW`, 16, count/bound width.
- `clk` in 1, clock.
- `rst_n` in 1, asynchronous active-low reset.
- `load_start_in` in 1, pulse; begins a table load.
- `entry_count_in` in 9, number of entries to load (0..256), sampled with `load_start_in`.
- `entry_in` in 24, `{symbol[7:0], range[15:0]}`.
- `entry_valid_in` in 1, entry present.
- `entry_ready_out` out 1, entry accepted when valid&ready.
- `loaded_out` out 1, table complete and lookups allowed.
- `total_out` out 16, sum of loaded ranges.
- `overflow_out` out 1, sticky; the sum exceeded 0xFFFF.
- `target_in` in 16, scaled cumulative target.
- `lookup_valid_in` in 1, lookup request.
- `lookup_ready_out` out 1, request accepted when valid&ready.
- `symbol_out` out 8, matched symbol.
- `lower_bound_out` out 16, matched lower bound.
- `upper_bound_out` out 16, matched upper bound.
- `range_out` out 16, matched range.
- `miss_out` out 1, no entry owns the target.
- `lookup_valid_out` out 1, one-cycle result strobe; no backpressure.

## Operation
- States: IDLE, LOAD, READY, SEARCH, DONE.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Every output is 0.
  - Entry index, stored count and total are cleared.
- `load_start_in`:
  - Honoured only in IDLE or READY; ignored in LOAD, SEARCH and DONE.
  - Clears the total, the index, `overflow_out` and `loaded_out`.
  - Latches `entry_count_in`.
  - Goes to LOAD, or straight to READY when the count is 0.
- LOAD:
  - `entry_ready_out`=1.
  - Each accepted entry k stores symbol[k], range[k] and upper[k] = total + range; the running total is updated.
  - The sum is computed at 17 bits. If bit 16 is set, `overflow_out` is set and the total saturates at 0xFFFF.
  - After the final accepted entry, the next state is READY.
- READY:
  - `loaded_out`=1 and `lookup_ready_out`=1.
- Lookup acceptance:
  - If `overflow_out`=1, or `target_in` ≥ the total, or the count is 0: go to DONE with a miss.
  - Otherwise go to SEARCH at index 0.
- SEARCH:
  - Each cycle compares the target against upper[k].
  - The first k with target < upper[k] is the match. This handles duplicate symbols and zero-range entries, which can never match.
  - Result registers: symbol[k], lower = upper[k] − range[k], upper[k], range[k].
  - Then go to DONE.
- DONE:
  - `lookup_valid_out`=1 for exactly one cycle, then return to READY.
  - On a miss: `miss_out`=1, and symbol and bounds read 0.
- Result outputs hold their values until the next DONE.
- `lookup_valid_in` outside READY is ignored. `entry_valid_in` outside LOAD is ignored.
- Storage: a register array or distributed RAM; at most one write per cycle in LOAD and one read per cycle in SEARCH.

## Timing
- Entry throughput is one per cycle.
- `loaded_out` rises the cycle after the last entry handshake, or the cycle after `load_start_in` when the count is 0.
- For a lookup accepted in cycle t and matching index k, `lookup_valid_out` is asserted in cycle t+2+k.
- A miss is reported in cycle t+1.
- `lookup_ready_out` is low from t+1 until the cycle after the DONE cycle (READY again).
- If a lookup and `load_start_in` arrive in the same READY cycle, the load wins and the lookup is not accepted.
- `rst_n` asserted mid-LOAD or mid-SEARCH clears everything immediately; no result strobe is issued.

## Test plan
- Load 3 entries {0x41,3},{0x42,5},{0x43,2} with `entry_valid_in` stuck high -> `entry_ready_out` high for 3 cycles, `loaded_out`=1 next cycle, `total_out`=10, `overflow_out`=0.
- After that load, targets 0, 7, 9 -> respectively:
  - target 0: symbol 0x41, lower 0, upper 3, range 3, strobe at t+2.
  - target 7: symbol 0x42, lower 3, upper 8, range 5, strobe at t+3.
  - target 9: symbol 0x43, lower 8, upper 10, range 2, strobe at t+4.
- Miss cases:
  - Target 10 -> `miss_out`=1, strobe at t+1.
  - Load with count 0 then any target -> READY immediately, miss at t+1.
- Load {0x10,0x8000},{0x11,0x8000} -> `overflow_out`=1, `total_out`=0xFFFF, every lookup misses.
- Load {0x20,0},{0x21,4},{0x20,4} then target 0 -> symbol 0x21, lower 0, upper 4. Target 5 -> symbol 0x20, lower 4, upper 8.
- Reset and ignored requests:
  - Deassert `entry_valid_in` mid-load for 4 cycles, then drop `rst_n` -> all outputs 0 asynchronously, IDLE.
  - `load_start_in` during SEARCH -> ignored; the lookup result is still delivered.

Source files
------------

// File: rtl/model_table_decoder_if.sv
// Bundled table-load and lookup signals for model_table_decoder.
// Master drives requests and entries; slave is the decoder itself.
interface model_table_decoder_if #(
    parameter int unsigned MAX_ENTRIES = 256,
    parameter int unsigned CW          = 16
);
    localparam int unsigned NW = $clog2(MAX_ENTRIES + 1);

    logic          load_start_in;
    logic [NW-1:0] entry_count_in;
    logic [CW+7:0] entry_in;
    logic          entry_valid_in;
    logic          entry_ready_out;
    logic          loaded_out;
    logic [CW-1:0] total_out;
    logic          overflow_out;
    logic [CW-1:0] target_in;
    logic          lookup_valid_in;
    logic          lookup_ready_out;
    logic [7:0]    symbol_out;
    logic [CW-1:0] lower_bound_out;
    logic [CW-1:0] upper_bound_out;
    logic [CW-1:0] range_out;
    logic          miss_out;
    logic          lookup_valid_out;

    modport master (
        output load_start_in, entry_count_in, entry_in, entry_valid_in, target_in,
               lookup_valid_in,
        input  entry_ready_out, loaded_out, total_out, overflow_out, lookup_ready_out,
               symbol_out, lower_bound_out, upper_bound_out, range_out, miss_out,
               lookup_valid_out
    );

    modport slave (
        input  load_start_in, entry_count_in, entry_in, entry_valid_in, target_in,
               lookup_valid_in,
        output entry_ready_out, loaded_out, total_out, overflow_out, lookup_ready_out,
               symbol_out, lower_bound_out, upper_bound_out, range_out, miss_out,
               lookup_valid_out
    );
endinterface

// File: rtl/model_table_decoder.sv
// Decoder-side model table: loads {symbol, range} entries in first-seen order, rebuilds
// cumulative upper bounds, and resolves scaled targets to their owning symbol by linear search.
module model_table_decoder #(
    parameter int unsigned MAX_ENTRIES = 256,
    parameter int unsigned CW          = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    model_table_decoder_if.slave bus
);
    localparam int unsigned IW = $clog2(MAX_ENTRIES);
    localparam int unsigned NW = $clog2(MAX_ENTRIES + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StReady, StSearch, StDone} state_e;

    state_e        state_q, state_d;
    logic [NW-1:0] count_q, count_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [CW-1:0] total_q, total_d;
    logic [CW-1:0] target_q, target_d;
    logic          overflow_q, overflow_d;
    logic          loaded_q, loaded_d;
    logic [7:0]    sym_q, sym_d;
    logic [CW-1:0] lower_q, lower_d;
    logic [CW-1:0] upper_q, upper_d;
    logic [CW-1:0] range_q, range_d;
    logic          miss_q, miss_d;

    logic [7:0]    sym_mem   [MAX_ENTRIES];
    logic [CW-1:0] range_mem [MAX_ENTRIES];
    logic [CW-1:0] upper_mem [MAX_ENTRIES];

    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [7:0]    in_sym;
    logic [CW-1:0] in_range;
    logic [CW:0]   sum;
    logic [CW-1:0] new_upper;
    logic [NW-1:0] idx_inc;

    assign in_sym    = bus.entry_in[CW+7:CW];
    assign in_range  = bus.entry_in[CW-1:0];
    assign mem_idx   = idx_q[IW-1:0];
    assign idx_inc   = idx_q + NW'(1);
    assign sum       = {1'b0, total_q} + {1'b0, in_range};
    assign new_upper = sum[CW] ? {CW{1'b1}} : sum[CW-1:0];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        total_d    = total_q;
        target_d   = target_q;
        overflow_d = overflow_q;
        loaded_d   = loaded_q;
        sym_d      = sym_q;
        lower_d    = lower_q;
        upper_d    = upper_q;
        range_d    = range_q;
        miss_d     = miss_q;
        mem_we     = 1'b0;
        unique case (state_q)
            StIdle, StReady: begin
                // A load request takes priority over a lookup in the same cycle.
                if (bus.load_start_in) begin
                    count_d    = (bus.entry_count_in > NW'(MAX_ENTRIES)) ? NW'(MAX_ENTRIES)
                                                                         : bus.entry_count_in;
                    idx_d      = '0;
                    total_d    = '0;
                    overflow_d = 1'b0;
                    loaded_d   = 1'b0;
                    if (bus.entry_count_in == '0) begin
                        state_d  = StReady;
                        loaded_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end else if (state_q == StReady && bus.lookup_valid_in) begin
                    target_d = bus.target_in;
                    idx_d    = '0;
                    if (overflow_q || bus.target_in >= total_q || count_q == '0) begin
                        state_d = StDone;
                        miss_d  = 1'b1;
                        sym_d   = '0;
                        lower_d = '0;
                        upper_d = '0;
                        range_d = '0;
                    end else begin
                        state_d = StSearch;
                    end
                end
            end
            StLoad: begin
                if (bus.entry_valid_in) begin
                    mem_we     = 1'b1;
                    total_d    = new_upper;
                    overflow_d = overflow_q | sum[CW];
                    idx_d      = idx_inc;
                    if (idx_inc == count_q) begin
                        state_d  = StReady;
                        loaded_d = 1'b1;
                    end
                end
            end
            StSearch: begin
                // Zero-range entries have upper == lower and can never satisfy target < upper.
                if (target_q < upper_mem[mem_idx]) begin
                    state_d = StDone;
                    miss_d  = 1'b0;
                    sym_d   = sym_mem[mem_idx];
                    lower_d = upper_mem[mem_idx] - range_mem[mem_idx];
                    upper_d = upper_mem[mem_idx];
                    range_d = range_mem[mem_idx];
                end else if (idx_inc >= count_q) begin
                    state_d = StDone;
                    miss_d  = 1'b1;
                    sym_d   = '0;
                    lower_d = '0;
                    upper_d = '0;
                    range_d = '0;
                end else begin
                    idx_d = idx_inc;
                end
            end
            StDone:  state_d = StReady;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            idx_q      <= '0;
            total_q    <= '0;
            target_q   <= '0;
            overflow_q <= 1'b0;
            loaded_q   <= 1'b0;
            sym_q      <= '0;
            lower_q    <= '0;
            upper_q    <= '0;
            range_q    <= '0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            total_q    <= total_d;
            target_q   <= target_d;
            overflow_q <= overflow_d;
            loaded_q   <= loaded_d;
            sym_q      <= sym_d;
            lower_q    <= lower_d;
            upper_q    <= upper_d;
            range_q    <= range_d;
            miss_q     <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            sym_mem[mem_idx]   <= in_sym;
            range_mem[mem_idx] <= in_range;
            upper_mem[mem_idx] <= new_upper;
        end
    end

    assign bus.entry_ready_out  = (state_q == StLoad);
    assign bus.lookup_ready_out = (state_q == StReady);
    assign bus.lookup_valid_out = (state_q == StDone);
    assign bus.loaded_out       = loaded_q;
    assign bus.total_out        = total_q;
    assign bus.overflow_out     = overflow_q;
    assign bus.symbol_out       = sym_q;
    assign bus.lower_bound_out  = lower_q;
    assign bus.upper_bound_out  = upper_q;
    assign bus.range_out        = range_q;
    assign bus.miss_out         = miss_q;
endmodule

// File: tb/tb_model_table_decoder.sv
// Self-checking bench for model_table_decoder: directed table loads plus randomized tables and
// targets, checked against a cumulative-sum reference model.
module tb_model_table_decoder;
    logic clk;
    logic rst_n;

    model_table_decoder_if #(.MAX_ENTRIES(256), .CW(16)) bus ();

    model_table_decoder #(.MAX_ENTRIES(256), .CW(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  m_sym [256];
    logic [15:0] m_rng [256];
    int          m_n;
    int          m_total;
    bit          m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic load_table(input int n, input bit gaps);
        int budget;
        int sum;
        @(negedge clk);
        bus.load_start_in  = 1'b1;
        bus.entry_count_in = 9'(n);
        @(negedge clk);
        bus.load_start_in = 1'b0;
        if (n > 0) check_eq("loaded_clr", bus.loaded_out, 0);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.entry_valid_in = 1'b0;
                    @(negedge clk);
                end
            end
            bus.entry_valid_in = 1'b1;
            bus.entry_in       = {m_sym[k], m_rng[k]};
            budget = 0;
            while (!bus.entry_ready_out && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 20) check_eq("entry_ready_timeout", 0, 1);
            @(negedge clk);
        end
        bus.entry_valid_in = 1'b0;
        sum = 0;
        for (int k = 0; k < n; k++) sum += int'(m_rng[k]);
        m_n     = n;
        m_ovf   = (sum > 65535);
        m_total = m_ovf ? 65535 : sum;
        check_eq("loaded", bus.loaded_out, 1);
        check_eq("total", bus.total_out, 32'(m_total));
        check_eq("overflow", bus.overflow_out, 32'(m_ovf));
    endtask

    task automatic do_lookup(input logic [15:0] tgt, input bit inject_load);
        int   lat_e, lat, cum, lo;
        bit   miss_e;
        logic [7:0]  s_e;
        logic [15:0] lo_e, up_e, r_e;
        miss_e = 1'b1; lat_e = 1; s_e = '0; lo_e = '0; up_e = '0; r_e = '0;
        if (!(m_ovf || int'(tgt) >= m_total || m_n == 0)) begin
            cum = 0;
            for (int k = 0; k < m_n; k++) begin
                lo  = cum;
                cum += int'(m_rng[k]);
                if (int'(tgt) < cum) begin
                    miss_e = 1'b0; lat_e = k + 2; s_e = m_sym[k];
                    lo_e = 16'(lo); up_e = 16'(cum); r_e = m_rng[k];
                    break;
                end
            end
        end
        check_eq("lk_ready", bus.lookup_ready_out, 1);
        bus.lookup_valid_in = 1'b1;
        bus.target_in       = tgt;
        @(negedge clk);
        bus.lookup_valid_in = 1'b0;
        lat = 1;
        if (inject_load) begin
            bus.load_start_in  = 1'b1;
            bus.entry_count_in = '0;
        end
        while (!bus.lookup_valid_out && lat < 300) begin
            @(negedge clk);
            bus.load_start_in = 1'b0;
            lat++;
        end
        bus.load_start_in = 1'b0;
        check_eq("lk_latency", 32'(lat), 32'(lat_e));
        check_eq("lk_miss", bus.miss_out, 32'(miss_e));
        check_eq("lk_symbol", bus.symbol_out, 32'(s_e));
        check_eq("lk_lower", bus.lower_bound_out, 32'(lo_e));
        check_eq("lk_upper", bus.upper_bound_out, 32'(up_e));
        check_eq("lk_range", bus.range_out, 32'(r_e));
        @(negedge clk);
        check_eq("lk_strobe_1cyc", bus.lookup_valid_out, 0);
        check_eq("lk_ready_again", bus.lookup_ready_out, 1);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.load_start_in   = 1'b0;
        bus.entry_count_in  = '0;
        bus.entry_in        = '0;
        bus.entry_valid_in  = 1'b0;
        bus.target_in       = '0;
        bus.lookup_valid_in = 1'b0;
        m_n = 0; m_total = 0; m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_entry_ready", bus.entry_ready_out, 0);
        check_eq("rst_loaded", bus.loaded_out, 0);
        check_eq("rst_total", bus.total_out, 0);
        check_eq("rst_lookup_ready", bus.lookup_ready_out, 0);
        check_eq("rst_lookup_valid", bus.lookup_valid_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic three-entry table
        m_sym[0] = 8'h41; m_rng[0] = 16'd3;
        m_sym[1] = 8'h42; m_rng[1] = 16'd5;
        m_sym[2] = 8'h43; m_rng[2] = 16'd2;
        load_table(3, 1'b0);
        check_eq("plan_total10", bus.total_out, 10);
        do_lookup(16'd0, 1'b0);
        check_eq("plan_t0_sym", bus.symbol_out, 8'h41);
        do_lookup(16'd7, 1'b0);
        do_lookup(16'd9, 1'b0);
        do_lookup(16'd10, 1'b0);

        load_table(0, 1'b0);
        do_lookup(16'd0, 1'b0);
        do_lookup(16'(($urandom)), 1'b0);

        m_sym[0] = 8'h10; m_rng[0] = 16'h8000;
        m_sym[1] = 8'h11; m_rng[1] = 16'h8000;
        load_table(2, 1'b0);
        do_lookup(16'd0, 1'b0);
        do_lookup(16'h7fff, 1'b0);

        m_sym[0] = 8'h20; m_rng[0] = 16'd0;
        m_sym[1] = 8'h21; m_rng[1] = 16'd4;
        m_sym[2] = 8'h20; m_rng[2] = 16'd4;
        load_table(3, 1'b0);
        do_lookup(16'd0, 1'b0);
        do_lookup(16'd5, 1'b0);

        // A load request during SEARCH must not disturb the lookup or the table
        for (int k = 0; k < 5; k++) begin
            m_sym[k] = 8'(8'h60 + k);
            m_rng[k] = 16'd1;
        end
        load_table(5, 1'b1);
        do_lookup(16'd4, 1'b1);
        check_eq("inject_total", bus.total_out, 5);
        check_eq("inject_loaded", bus.loaded_out, 1);

        // Asynchronous reset in the middle of a stalled load
        for (int k = 0; k < 5; k++) m_rng[k] = 16'd3;
        @(negedge clk);
        bus.load_start_in  = 1'b1;
        bus.entry_count_in = 9'd5;
        @(negedge clk);
        bus.load_start_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.entry_valid_in = 1'b1;
            bus.entry_in       = {m_sym[k], m_rng[k]};
            @(negedge clk);
        end
        bus.entry_valid_in = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("partial_total", bus.total_out, 6);
        check_eq("partial_ready", bus.entry_ready_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_entry_ready", bus.entry_ready_out, 0);
        check_eq("arst_total", bus.total_out, 0);
        check_eq("arst_loaded", bus.loaded_out, 0);
        check_eq("arst_symbol", bus.symbol_out, 0);
        check_eq("arst_upper", bus.upper_bound_out, 0);
        check_eq("arst_lookup_valid", bus.lookup_valid_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_lookup_ready", bus.lookup_ready_out, 0);
        m_n = 0; m_total = 0; m_ovf = 1'b0;

        // Randomized tables and targets
        for (int r = 0; r < 20; r++) begin
            int n;
            bit big;
            n   = $urandom_range(1, 16);
            big = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < n; k++) begin
                m_sym[k] = 8'($urandom);
                m_rng[k] = big ? 16'($urandom_range(16'h2000, 16'h9000))
                               : 16'($urandom_range(0, 9));
            end
            load_table(n, 1'b1);
            for (int j = 0; j < 6; j++) do_lookup(16'($urandom_range(0, m_total + 2)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
